muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_ctrl_pkg.sv | 50 +++++
 rtl/muldiv_ctrl_if.sv | 32 +++
 rtl/muldiv_ctrl_step.sv | 46 ++++
 rtl/muldiv_ctrl.sv | 164 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg
// Shared definitions for the EX-stage multiply/divide sequencer:
//   - MD_* operation codes driven on op by the main decoder
//   - FSM state encoding used by muldiv_ctrl
//   - R-type funct codes for MULT/MULTU/DIV/DIVU and their op mapping
package muldiv_ctrl_pkg;

    // Operation select codes: bit 1 = divide, bit 0 = unsigned
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    // R-type funct field values for the HI/LO arithmetic instructions
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // Main decoder helper: funct field to sequencer op code
    function automatic logic [1:0] functToOp(input logic [5:0] funct);
        logic [1:0] op;
        op = MD_MULT;
        case (funct)
            FUNCT_MULT:  op = MD_MULT;
            FUNCT_MULTU: op = MD_MULTU;
            FUNCT_DIV:   op = MD_DIV;
            FUNCT_DIVU:  op = MD_DIVU;
            default:     op = MD_MULT;
        endcase
        return op;
    endfunction

    function automatic logic isDivOp(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic isSignedOp(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if
// Request/result bundle between the EX stage (master) and the
// multiply/divide sequencer (slave).
//   start/op/a/b/flush : request side, driven by the pipeline
//   stall/done/hilo_we : status back to the pipeline and HI/LO writeback
//   hi/lo              : 2*WIDTH result (product halves or remainder/quotient)
interface muldiv_ctrl_if
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             done;
    logic             hilo_we;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  stall, done, hilo_we, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output stall, done, hilo_we, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl_step.sv
// muldiv_step
// Combinational single-iteration datapath shared by multiply and divide.
//   isDiv_i          : 1 = restoring-divide step, 0 = shift-add multiply step
//   accHi_i/accLo_i  : current accumulator (partial product, or {rem, quo})
//   operand_i        : multiplicand (multiply) or divisor magnitude (divide)
//   accHi_o/accLo_o  : accumulator after one iteration
module muldiv_step
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             isDiv_i,
    input  logic [WIDTH-1:0] accHi_i,
    input  logic [WIDTH-1:0] accLo_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] accHi_o,
    output logic [WIDTH-1:0] accLo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] remShift;
    logic [WIDTH:0] diff;

    // The multiply sum keeps its carry so the right shift brings it into the
    // top of the partial product. The divide trial uses WIDTH+1 bits because the
    // shifted remainder can exceed WIDTH bits. The remainder is always below the
    // divisor before the shift, so diff stays within WIDTH+1-bit signed range and
    // bit WIDTH is a true sign.
    always_comb begin
        sum      = {1'b0, accHi_i} + (accLo_i[0] ? {1'b0, operand_i} : '0);
        remShift = {accHi_i, accLo_i[WIDTH-1]};
        diff     = remShift - {1'b0, operand_i};
        accHi_o  = sum[WIDTH:1];
        accLo_o  = {sum[0], accLo_i[WIDTH-1:1]};
        if (isDiv_i) begin
            if (!diff[WIDTH]) begin
                accHi_o = diff[WIDTH-1:0];
                accLo_o = {accLo_i[WIDTH-2:0], 1'b1};
            end else begin
                accHi_o = remShift[WIDTH-1:0];
                accLo_o = {accLo_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage. It runs one
// iteration per clock on operand magnitudes, fixes the signs at the end, and
// pulses done/hilo_we for one cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of muldiv_ctrl_if (request in, stall/result out)
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_ctrl_if.slave   bus
);

    localparam int COUNT_W = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]   accHi_q, accHi_d;
    logic [WIDTH-1:0]   accLo_q, accLo_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic               isDiv_q, isDiv_d;
    logic               divZero_q, divZero_d;
    logic               negQuo_q, negQuo_d;
    logic               negRem_q, negRem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               signedOp;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH-1:0]   stepHi, stepLo;
    logic [2*WIDTH-1:0] product;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .isDiv_i   (isDiv_q),
        .accHi_i   (accHi_q),
        .accLo_i   (accLo_q),
        .operand_i (operand_q),
        .accHi_o   (stepHi),
        .accLo_o   (stepLo)
    );

    // Operand magnitudes. The most negative value negates to itself, which
    // is exactly its magnitude when read as an unsigned number.
    always_comb begin
        signedOp = isSignedOp(bus.op);
        absA     = (signedOp && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        absB     = (signedOp && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        product  = negQuo_q ? -{accHi_q, accLo_q} : {accHi_q, accLo_q};
    end

    // Next-state logic. A flush in any state sends the FSM back to IDLE and
    // leaves hi/lo untouched.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        accHi_d   = accHi_q;
        accLo_d   = accLo_q;
        operand_d = operand_q;
        isDiv_d   = isDiv_q;
        divZero_d = divZero_q;
        negQuo_d  = negQuo_q;
        negRem_d  = negRem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    isDiv_d   = isDivOp(bus.op);
                    divZero_d = isDivOp(bus.op) && (bus.b == '0);
                    negQuo_d  = signedOp && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    negRem_d  = signedOp && bus.a[WIDTH-1];
                    accHi_d   = '0;
                    count_d   = '0;
                    if (isDivOp(bus.op)) begin
                        accLo_d   = (bus.b == '0) ? bus.a : absA;
                        operand_d = absB;
                    end else begin
                        accLo_d   = absB;
                        operand_d = absA;
                    end
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A divide by zero keeps the raw dividend parked in accLo.
                if (!divZero_q) begin
                    accHi_d = stepHi;
                    accLo_d = stepLo;
                end
                count_d = count_q + 1'b1;
                if (count_q == COUNT_W'(WIDTH - 1)) begin
                    count_d = '0;
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (divZero_q) begin
                    hi_d = accLo_q;
                    lo_d = '1;
                end else if (isDiv_q) begin
                    hi_d = negRem_q ? -accHi_q : accHi_q;
                    lo_d = negQuo_q ? -accLo_q : accLo_q;
                end else begin
                    hi_d = product[2*WIDTH-1:WIDTH];
                    lo_d = product[WIDTH-1:0];
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.flush) begin
            state_d = ST_IDLE;
            count_d = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            operand_q <= '0;
            isDiv_q   <= 1'b0;
            divZero_q <= 1'b0;
            negQuo_q  <= 1'b0;
            negRem_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            accHi_q   <= accHi_d;
            accLo_q   <= accLo_d;
            operand_q <= operand_d;
            isDiv_q   <= isDiv_d;
            divZero_q <= divZero_d;
            negQuo_q  <= negQuo_d;
            negRem_q  <= negRem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // stall drops in DONE so the pipeline advances while HI/LO are written.
    assign bus.stall   = ((state_q == ST_IDLE) && bus.start && !bus.flush)
                       || (state_q == ST_RUN) || (state_q == ST_FIX);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.hilo_we = (state_q == ST_DONE);
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
// Self-checking bench for muldiv_ctrl: directed and randomized operations
// compared against a plain-arithmetic reference model, plus flush, reset
// and ignored-start scenarios.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 2;
    localparam int WATCH   = LATENCY + 8;

    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] expHi = '0;
    logic [WIDTH-1:0] expLo = '0;

    muldiv_ctrl_if #(.WIDTH(WIDTH)) bus ();

    muldiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it when it does not match.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference result {hi, lo} from ordinary signed/unsigned 64-bit arithmetic.
    function automatic logic [63:0] modelResult(input logic [1:0] op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (op)
            MD_MULT:  r = 64'(sa * sb);
            MD_MULTU: r = ua * ub;
            MD_DIV: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    r  = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    // Runs one operation from the current negedge. If pokeAt > 0, start is
    // pulsed again in that cycle with other operands and must be ignored.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int pokeAt,
                                 input string name);
        logic [63:0] expected;
        logic [31:0] gotHi, gotLo;
        int          doneCyc, doneCount;
        bit          stallOk, weOk;
        expected  = modelResult(op, a, b);
        gotHi     = 'x;
        gotLo     = 'x;
        doneCyc   = -1;
        doneCount = 0;
        stallOk   = 1'b1;
        weOk      = 1'b1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        #1;
        if (bus.stall !== 1'b1) stallOk = 1'b0;
        for (int cyc = 1; cyc <= WATCH; cyc++) begin
            @(negedge clk);
            bus.start = (cyc == pokeAt);
            if (cyc == pokeAt) begin
                bus.op = 2'($urandom_range(0, 3));
                bus.a  = $urandom;
                bus.b  = $urandom;
            end
            #1;
            if (bus.stall !== (cyc < LATENCY)) stallOk = 1'b0;
            if (bus.hilo_we !== bus.done) weOk = 1'b0;
            if (bus.done === 1'b1) begin
                doneCount++;
                if (doneCyc < 0) begin
                    doneCyc = cyc;
                    gotHi   = bus.hi;
                    gotLo   = bus.lo;
                end
            end
        end
        checkOutput({name, ".latency"}, 64'(doneCyc), 64'(LATENCY));
        checkOutput({name, ".doneCount"}, 64'(doneCount), 64'd1);
        checkOutput({name, ".stall"}, 64'(stallOk), 64'd1);
        checkOutput({name, ".hilo_we"}, 64'(weOk), 64'd1);
        checkOutput({name, ".hi"}, 64'(gotHi), 64'(expected[63:32]));
        checkOutput({name, ".lo"}, 64'(gotLo), 64'(expected[31:0]));
        checkOutput({name, ".hold"}, {bus.hi, bus.lo}, expected);
        expHi = expected[63:32];
        expLo = expected[31:0];
    endtask

    // Starts an operation and cancels it with flush (or rst) during cycle atCyc.
    task automatic applyAbort(input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int atCyc,
                              input bit useRst, input string name);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        for (int cyc = 1; cyc <= atCyc; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (cyc == atCyc) begin
                if (useRst) rst = 1'b1;
                else bus.flush = 1'b1;
            end
        end
        @(negedge clk);
        rst       = 1'b0;
        bus.flush = 1'b0;
        #1;
        if (useRst) begin
            expHi = '0;
            expLo = '0;
        end
        checkOutput({name, ".stall"}, 64'(bus.stall), 64'd0);
        checkOutput({name, ".done"}, 64'(bus.done), 64'd0);
        checkOutput({name, ".hilo_we"}, 64'(bus.hilo_we), 64'd0);
        checkOutput({name, ".hilo"}, {bus.hi, bus.lo}, {expHi, expLo});
    endtask

    // start and flush together in IDLE: nothing may happen.
    task automatic applyStartFlush();
        int busy;
        busy      = 0;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = MD_MULTU;
        bus.a     = $urandom;
        bus.b     = $urandom;
        #1;
        checkOutput("startFlush.stall0", 64'(bus.stall), 64'd0);
        for (int cyc = 1; cyc <= WATCH; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.flush = 1'b0;
            #1;
            if (bus.done !== 1'b0 || bus.stall !== 1'b0) busy++;
        end
        checkOutput("startFlush.quiet", 64'(busy), 64'd0);
        checkOutput("startFlush.hilo", {bus.hi, bus.lo}, {expHi, expLo});
    endtask

    initial begin
        logic [1:0]  rOp;
        logic [31:0] rA, rB;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = MD_MULT;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset.stall", 64'(bus.stall), 64'd0);
        checkOutput("reset.done", 64'(bus.done), 64'd0);
        checkOutput("reset.hilo_we", 64'(bus.hilo_we), 64'd0);
        checkOutput("reset.hilo", {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(MD_MULT,  32'hFFFF_FFFD, 32'd7,        0, "multNeg");
        checkOutput("multNeg.const", {expHi, expLo}, 64'hFFFF_FFFF_FFFF_FFEB);
        applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multuMax");
        checkOutput("multuMax.const", {expHi, expLo}, 64'hFFFF_FFFE_0000_0001);
        applyStimulus(MD_DIVU,  32'd100,       32'd7,        0, "divu");
        applyStimulus(MD_DIV,   32'hFFFF_FFF9, 32'd2,        0, "divNeg");
        checkOutput("divNeg.const", {expHi, expLo}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, "divWrap");
        checkOutput("divWrap.const", {expHi, expLo}, 64'h0000_0000_8000_0000);
        applyStimulus(MD_DIVU,  32'd5,         32'd0,        0, "divZero");
        applyStimulus(MD_DIV,   32'hFFFF_FFF0, 32'd0,        0, "divZeroSigned");

        applyAbort(MD_DIVU, 32'd1000, 32'd3, 10, 1'b0, "flush");
        applyStimulus(MD_MULTU, 32'd3, 32'd4, 0, "afterFlush");
        applyStimulus(MD_DIV, 32'h1234_5678, 32'hFFFF_FF00, 5, "ignoreStart");
        applyStartFlush();
        applyAbort(MD_MULT, 32'h7654_3210, 32'h89AB_CDEF, 20, 1'b1, "rstMid");
        applyStimulus(MD_MULT, 32'h8000_0000, 32'h8000_0000, 0, "multMinMin");

        for (int i = 0; i < 24; i++) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = $urandom;
            case ($urandom_range(0, 7))
                0:       rB = 32'd0;
                1:       rB = $urandom_range(1, 15);
                2:       rB = 32'hFFFF_FFFF;
                default: rB = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) rA = $urandom_range(0, 255);
            applyStimulus(rOp, rA, rB, 0, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
